frame_sequencer: RTL and testbench
==================================

// Module: frame_sequencer
// PURPOSE
//  Initiator side of the screen-clear handshake. It times the inter-frame wait and raises clear_req
//  (drives the clearer's waited input). It muxes the clearer's x/y walk onto the framebuffer write
//  port until cleared is seen, then hands the port to the drawing engine for one frame and loops.
//  Sits between the VGA framebuffer write port, the screen clearer and the drawing engine.
// PARAMETERS
//  WAIT_CYCLES    25_000_000  clk cycles spent in WAIT per frame (>=1)
//  H_RES          640         visible width; x >= H_RES never written
//  V_RES          480         visible height; y >= V_RES never written
//  COLOR_W        1           pixel colour width
//  CLEAR_COLOR    0           colour written during CLEAR
//  CLEAR_TIMEOUT  400_000     CLEAR watchdog limit in cycles (FRAME_SEQ_TIMEOUT_EN only)
// PORTS
//  clk          in   1        system clock
//  reset        in   1        synchronous, active-high
//  enable       in   1        run frames; sampled at frame boundaries
//  clr_x        in   10       clearer x coordinate
//  clr_y        in   9        clearer y coordinate
//  cleared      in   1        clearer finished; valid only while clear_req=1
//  clear_req    out  1        request clear; held high until cleared seen (clearer's waited)
//  draw_start   out  1        1-cycle pulse on entry to DRAW
//  draw_x       in   10       drawer pixel x
//  draw_y       in   9        drawer pixel y
//  draw_color   in   COLOR_W  drawer pixel colour
//  draw_valid   in   1        drawer pixel write strobe
//  draw_done    in   1        drawer finished frame
//  fb_x         out  10       framebuffer write x
//  fb_y         out  9        framebuffer write y
//  fb_color     out  COLOR_W  framebuffer write colour
//  fb_we        out  1        framebuffer write enable
//  phase        out  2        0=IDLE 1=WAIT 2=CLEAR 3=DRAW
//  frame_count  out  16       completed frames, wraps 0xFFFF->0
//  timeout_err  out  1        sticky CLEAR watchdog flag
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0: clear_req, draw_start, fb_*, phase, frame_count, timeout_err.
//    The wait counter is also cleared. Reset mid-frame aborts immediately.
//  - IDLE: enable=1 -> WAIT with the counter at 0.
//  - WAIT: counter +1 per cycle. At count==WAIT_CYCLES-1 -> CLEAR.
//    enable=0 during WAIT -> IDLE next cycle. cleared is ignored in WAIT.
//  - CLEAR: clear_req=1 from the first CLEAR cycle, registered. cleared=1 -> DRAW.
//    clear_req drops in the same cycle DRAW is entered. draw_start=1 for that single cycle.
//  - DRAW: draw_done=1 -> frame_count+1 (mod 2^16). Next state is WAIT if enable=1, else IDLE.
//    A draw_done in the same cycle as draw_start is honoured.
//  - enable=0 in CLEAR or DRAW does not abort; the frame completes first.
//  - fb mux: all fb_* outputs are registered, giving 1-cycle latency from the selected source.
//    CLEAR: fb_x/fb_y = clr_x/clr_y, fb_color = CLEAR_COLOR.
//      fb_we = (clr_x < H_RES) && (clr_y < V_RES); this drops the clearer's x==640 and y==480 steps.
//    DRAW: fb_x/fb_y/fb_color = draw_*, fb_we = draw_valid && in-bounds.
//    IDLE/WAIT: fb_we = 0. fb_x, fb_y and fb_color hold.
//  - draw_valid outside DRAW and clr_* outside CLEAR never cause writes.
// CONFIGURATION
//  FRAME_SEQ_TIMEOUT_EN defined:
//    - A cycle counter runs in CLEAR.
//    - If it reaches CLEAR_TIMEOUT without cleared, force DRAW as if cleared arrived (draw_start pulses).
//    - timeout_err is set and stays set until reset.
//  FRAME_SEQ_TIMEOUT_EN undefined: CLEAR waits indefinitely; timeout_err is tied 0.
// TESTING  (WAIT_CYCLES=4, H_RES=4, V_RES=3 unless noted)
//  1 Reset, enable=1 -> phase 1 for 4 cycles, then phase 2 with clear_req=1.
//    cleared=1 -> next cycle phase 3, clear_req=0, draw_start=1 for 1 cycle.
//  2 CLEAR, clr walks x 0..4 and y 0..3 -> exactly 12 fb_we pulses.
//    Each pulse is 1 cycle after its source coordinate, fb_color=0. None at x=4 or y=3.
//  3 DRAW, draw_valid=1 at (2,1,colour 1) -> fb_we=1, fb=(2,1,1) next cycle.
//    draw_valid=1 at (5,1) -> fb_we=0. draw_done -> frame_count=1, phase 1.
//  4 enable=0 mid-DRAW, then draw_done -> phase 0, frame_count increments.
//    enable=0 mid-WAIT -> phase 0 next cycle; a cleared pulse in WAIT has no effect.
//  5 reset=1 mid-CLEAR -> next cycle phase 0, clear_req=0, fb_we=0, frame_count=0.
//  6 FRAME_SEQ_TIMEOUT_EN, CLEAR_TIMEOUT=8, cleared held 0 -> phase 3 after 8 CLEAR cycles.
//    draw_start pulses; timeout_err=1 and remains 1 after the next frame.

Source files
------------

// File: rtl/frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// frame_sequencer_if
// Bundles every non-clock/reset signal around the frame sequencer so that one
// handle connects the sequencer to the clearer, the drawing engine and the
// framebuffer write port.
//   master : the sequencer's view (drives clear_req, draw_start, fb_*, status)
//   slave  : the environment's view (drives enable, clearer and drawer inputs)
// Signals:
//   enable                         run frames, sampled at frame boundaries
//   clr_x/clr_y/cleared            screen clearer walk and completion
//   clear_req                      request to the clearer (its "waited" input)
//   draw_start                     1-cycle pulse on entry to DRAW
//   draw_x/y/color/valid/done      drawing engine pixel stream and completion
//   fb_x/fb_y/fb_color/fb_we       framebuffer write port
//   phase/frame_count/timeout_err  status
// ---------------------------------------------------------------------------
interface frame_sequencer_if #(
    parameter int COLOR_W = 1
);
    logic               enable;
    logic [9:0]         clr_x;
    logic [8:0]         clr_y;
    logic               cleared;
    logic               clear_req;
    logic               draw_start;
    logic [9:0]         draw_x;
    logic [8:0]         draw_y;
    logic [COLOR_W-1:0] draw_color;
    logic               draw_valid;
    logic               draw_done;
    logic [9:0]         fb_x;
    logic [8:0]         fb_y;
    logic [COLOR_W-1:0] fb_color;
    logic               fb_we;
    logic [1:0]         phase;
    logic [15:0]        frame_count;
    logic               timeout_err;

    modport master (
        input  enable, clr_x, clr_y, cleared,
               draw_x, draw_y, draw_color, draw_valid, draw_done,
        output clear_req, draw_start, fb_x, fb_y, fb_color, fb_we,
               phase, frame_count, timeout_err
    );

    modport slave (
        output enable, clr_x, clr_y, cleared,
               draw_x, draw_y, draw_color, draw_valid, draw_done,
        input  clear_req, draw_start, fb_x, fb_y, fb_color, fb_we,
               phase, frame_count, timeout_err
    );
endinterface

// File: rtl/frame_sequencer.sv
// ---------------------------------------------------------------------------
// frame_sequencer
// Initiator side of the screen-clear handshake. Loops IDLE -> WAIT -> CLEAR ->
// DRAW: times the inter-frame wait, raises clear_req until the clearer reports
// cleared, muxes the clearer's x/y walk onto the framebuffer write port during
// CLEAR and the drawing engine's pixel stream during DRAW.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; aborts any frame in progress
//   bus    frame_sequencer_if.master (see interface for signal list)
// Optional feature: define FRAME_SEQ_TIMEOUT_EN to add a CLEAR watchdog that
// forces DRAW after CLEAR_TIMEOUT cycles and sets the sticky timeout_err.
// Without it CLEAR waits indefinitely and timeout_err is tied 0.
// ---------------------------------------------------------------------------
module frame_sequencer #(
    parameter int WAIT_CYCLES   = 25_000_000,
    parameter int H_RES         = 640,
    parameter int V_RES         = 480,
    parameter int COLOR_W       = 1,
    parameter int CLEAR_COLOR   = 0,
    parameter int CLEAR_TIMEOUT = 400_000
) (
    input  logic              clk,
    input  logic              reset,
    frame_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DRAW  = 2'd3
    } state_t;

    localparam int                 WAIT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [31:0]        H_LIM     = 32'(H_RES);
    localparam logic [31:0]        V_LIM     = 32'(V_RES);
    localparam logic [COLOR_W-1:0] CLR_COLOR = COLOR_W'(CLEAR_COLOR);

    // Reject nonsensical cycle counts at elaboration time.
    if (WAIT_CYCLES < 1 || CLEAR_TIMEOUT < 1) begin : g_param_check
        $error("frame_sequencer: WAIT_CYCLES and CLEAR_TIMEOUT must be >= 1");
    end

    state_t             state_r;
    state_t             next_state_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic               wait_done_s;
    logic               timeout_hit_s;
    logic               clr_inb_s;
    logic               draw_inb_s;

    logic               clear_req_s,  clear_req_r;
    logic               draw_start_s, draw_start_r;
    logic               frame_inc_s;
    logic [9:0]         fb_x_s,       fb_x_r;
    logic [8:0]         fb_y_s,       fb_y_r;
    logic [COLOR_W-1:0] fb_color_s,   fb_color_r;
    logic               fb_we_s,      fb_we_r;
    logic [15:0]        frame_count_r;

    assign wait_done_s = (wait_cnt_r == WAIT_LAST);
    // The clearer walks one step past the visible area; those steps must not write.
    assign clr_inb_s   = ({22'd0, bus.clr_x} < H_LIM) && ({23'd0, bus.clr_y} < V_LIM);
    assign draw_inb_s  = ({22'd0, bus.draw_x} < H_LIM) && ({23'd0, bus.draw_y} < V_LIM);

`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam int              TO_W    = (CLEAR_TIMEOUT > 1) ? $clog2(CLEAR_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(CLEAR_TIMEOUT - 1);

    logic [TO_W-1:0] clr_cnt_r;
    logic            timeout_err_r;

    // Last CLEAR cycle the watchdog allows before forcing DRAW.
    assign timeout_hit_s   = (clr_cnt_r == TO_LAST);
    assign bus.timeout_err = timeout_err_r;

    // Watchdog: counts consecutive CLEAR cycles; flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt_r     <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            clr_cnt_r     <= (state_r == ST_CLEAR && next_state_s == ST_CLEAR)
                             ? clr_cnt_r + TO_W'(1) : '0;
            timeout_err_r <= timeout_err_r |
                             ((state_r == ST_CLEAR) && timeout_hit_s && !bus.cleared);
        end
    end
`else
    assign timeout_hit_s   = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic. enable only aborts a frame while waiting.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:  next_state_s = bus.enable ? ST_WAIT : ST_IDLE;
            ST_WAIT:  next_state_s = !bus.enable ? ST_IDLE :
                                     (wait_done_s ? ST_CLEAR : ST_WAIT);
            ST_CLEAR: next_state_s = (bus.cleared || timeout_hit_s) ? ST_DRAW : ST_CLEAR;
            ST_DRAW:  next_state_s = !bus.draw_done ? ST_DRAW :
                                     (bus.enable ? ST_WAIT : ST_IDLE);
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: handshake strobes from the transition, fb mux from the current state.
    always_comb begin
        clear_req_s  = (next_state_s == ST_CLEAR);
        draw_start_s = (state_r == ST_CLEAR) && (next_state_s == ST_DRAW);
        frame_inc_s  = (state_r == ST_DRAW) && bus.draw_done;
        fb_x_s       = fb_x_r;
        fb_y_s       = fb_y_r;
        fb_color_s   = fb_color_r;
        fb_we_s      = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                fb_x_s     = bus.clr_x;
                fb_y_s     = bus.clr_y;
                fb_color_s = CLR_COLOR;
                fb_we_s    = clr_inb_s;
            end
            ST_DRAW: begin
                fb_x_s     = bus.draw_x;
                fb_y_s     = bus.draw_y;
                fb_color_s = bus.draw_color;
                fb_we_s    = bus.draw_valid && draw_inb_s;
            end
            default: begin
                fb_we_s    = 1'b0;
            end
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r    <= '0;
            clear_req_r   <= 1'b0;
            draw_start_r  <= 1'b0;
            fb_x_r        <= 10'd0;
            fb_y_r        <= 9'd0;
            fb_color_r    <= '0;
            fb_we_r       <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            // Counter is zero on every entry to WAIT.
            wait_cnt_r    <= (state_r == ST_WAIT && next_state_s == ST_WAIT)
                             ? wait_cnt_r + WAIT_W'(1) : '0;
            clear_req_r   <= clear_req_s;
            draw_start_r  <= draw_start_s;
            fb_x_r        <= fb_x_s;
            fb_y_r        <= fb_y_s;
            fb_color_r    <= fb_color_s;
            fb_we_r       <= fb_we_s;
            frame_count_r <= frame_inc_s ? frame_count_r + 16'd1 : frame_count_r;
        end
    end

    assign bus.phase       = state_r;
    assign bus.clear_req   = clear_req_r;
    assign bus.draw_start  = draw_start_r;
    assign bus.fb_x        = fb_x_r;
    assign bus.fb_y        = fb_y_r;
    assign bus.fb_color    = fb_color_r;
    assign bus.fb_we       = fb_we_r;
    assign bus.frame_count = frame_count_r;
endmodule

// File: tb/tb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_sequencer
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural frame model kept in the bench.
// ---------------------------------------------------------------------------
module tb_frame_sequencer;
    localparam int WAIT_CYCLES   = 4;
    localparam int H_RES         = 4;
    localparam int V_RES         = 3;
    localparam int CLEAR_TIMEOUT = 8;
    localparam int P_IDLE = 0, P_WAIT = 1, P_CLEAR = 2, P_DRAW = 3;
`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    frame_sequencer_if #(.COLOR_W(1)) bus();

    frame_sequencer #(
        .WAIT_CYCLES  (WAIT_CYCLES),
        .H_RES        (H_RES),
        .V_RES        (V_RES),
        .COLOR_W      (1),
        .CLEAR_COLOR  (0),
        .CLEAR_TIMEOUT(CLEAR_TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int we_pulses = 0;

    // Behavioural model of the frame loop.
    int m_phase = 0, m_waited = 0, m_in_clear = 0, m_fc = 0;
    int m_fbx = 0, m_fby = 0, m_fbc = 0;
    bit m_we = 0, m_creq = 0, m_dstart = 0, m_terr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model using the inputs currently presented.
    task automatic model_edge();
        int nph;
        if (reset) begin
            m_phase = P_IDLE; m_waited = 0; m_in_clear = 0; m_fc = 0;
            m_fbx = 0; m_fby = 0; m_fbc = 0;
            m_we = 0; m_creq = 0; m_dstart = 0; m_terr = 0;
            return;
        end
        // The write port shows, one cycle late, whichever source owned this cycle.
        if (m_phase == P_CLEAR) begin
            m_fbx = int'(bus.clr_x); m_fby = int'(bus.clr_y); m_fbc = 0;
            m_we  = (m_fbx < H_RES) && (m_fby < V_RES);
        end else if (m_phase == P_DRAW) begin
            m_fbx = int'(bus.draw_x); m_fby = int'(bus.draw_y); m_fbc = int'(bus.draw_color);
            m_we  = bus.draw_valid && (m_fbx < H_RES) && (m_fby < V_RES);
        end else begin
            m_we  = 0;
        end
        nph = m_phase;
        case (m_phase)
            P_IDLE: if (bus.enable) begin nph = P_WAIT; m_waited = 0; end
            P_WAIT: begin
                m_waited++;
                if (!bus.enable) nph = P_IDLE;
                else if (m_waited >= WAIT_CYCLES) begin nph = P_CLEAR; m_in_clear = 0; end
            end
            P_CLEAR: begin
                m_in_clear++;
                if (bus.cleared) nph = P_DRAW;
                else if (TO_EN && m_in_clear >= CLEAR_TIMEOUT) begin nph = P_DRAW; m_terr = 1; end
            end
            default: if (bus.draw_done) begin
                m_fc = (m_fc + 1) % 65536;
                nph  = bus.enable ? P_WAIT : P_IDLE;
                m_waited = 0;
            end
        endcase
        m_dstart = (m_phase == P_CLEAR) && (nph == P_DRAW);
        m_creq   = (nph == P_CLEAR);
        m_phase  = nph;
    endtask

    // One clock: advance model at the edge, compare all outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (bus.fb_we === 1'b1) we_pulses++;
        check("phase",       32'(bus.phase),       32'(m_phase));
        check("clear_req",   32'(bus.clear_req),   32'(m_creq));
        check("draw_start",  32'(bus.draw_start),  32'(m_dstart));
        check("fb_we",       32'(bus.fb_we),       32'(m_we));
        check("fb_x",        32'(bus.fb_x),        32'(m_fbx));
        check("fb_y",        32'(bus.fb_y),        32'(m_fby));
        check("fb_color",    32'(bus.fb_color),    32'(m_fbc));
        check("frame_count", 32'(bus.frame_count), 32'(m_fc));
        check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
    endtask

    task automatic advance_to(input int p, input int budget);
        int n = 0;
        while (m_phase != p && n < budget) begin
            step();
            n++;
        end
        check("advance_to", 32'(bus.phase), 32'(p));
    endtask

    task automatic quiet_inputs();
        bus.enable = 1'b0; bus.clr_x = 10'd0; bus.clr_y = 9'd0; bus.cleared = 1'b0;
        bus.draw_x = 10'd0; bus.draw_y = 9'd0; bus.draw_color = 1'b0;
        bus.draw_valid = 1'b0; bus.draw_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        quiet_inputs();
        #1;
        step();
        step();
        check("reset_phase", 32'(bus.phase), 32'd0);
        check("reset_frame_count", 32'(bus.frame_count), 32'd0);

        // Wait for exactly WAIT_CYCLES, then CLEAR with clear_req.
        reset = 1'b0;
        bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_wait_phase", 32'(bus.phase), 32'd1);
        end
        step();
        check("t1_clear_phase", 32'(bus.phase), 32'd2);
        check("t1_clear_req", 32'(bus.clear_req), 32'd1);

        // Clearer walk including the out-of-range column and row.
        we_pulses = 0;
        for (int y = 0; y <= 3; y++) begin
            for (int x = 0; x <= 4; x++) begin
                bus.clr_x = 10'(x);
                bus.clr_y = 9'(y);
                step();
                check("t2_we", 32'(bus.fb_we), 32'((x < 4) && (y < 3)));
            end
        end
        check("t2_we_count", 32'(we_pulses), 32'd12);
        bus.cleared = 1'b1;
        step();
        bus.cleared = 1'b0;
        check("t1_draw_phase", 32'(bus.phase), 32'd3);
        check("t1_clear_req_drop", 32'(bus.clear_req), 32'd0);
        check("t1_draw_start", 32'(bus.draw_start), 32'd1);

        // Drawer pixels: in-bounds write, out-of-bounds suppressed, frame end.
        bus.draw_x = 10'd2; bus.draw_y = 9'd1; bus.draw_color = 1'b1; bus.draw_valid = 1'b1;
        step();
        check("t3_draw_start_low", 32'(bus.draw_start), 32'd0);
        check("t3_we", 32'(bus.fb_we), 32'd1);
        check("t3_pix", {bus.fb_x, bus.fb_y, bus.fb_color}, {10'd2, 9'd1, 1'b1});
        bus.draw_x = 10'd5;
        step();
        check("t3_oob_we", 32'(bus.fb_we), 32'd0);
        bus.draw_valid = 1'b0; bus.draw_done = 1'b1;
        step();
        bus.draw_done = 1'b0;
        check("t3_frame_count", 32'(bus.frame_count), 32'd1);
        check("t3_back_to_wait", 32'(bus.phase), 32'd1);

        // enable dropped mid-DRAW: frame completes, then IDLE.
        advance_to(P_CLEAR, 10);
        bus.cleared = 1'b1;
        step();
        bus.cleared = 1'b0;
        bus.enable = 1'b0;
        step();
        step();
        check("t4_draw_holds", 32'(bus.phase), 32'd3);
        bus.draw_done = 1'b1;
        step();
        bus.draw_done = 1'b0;
        check("t4_idle", 32'(bus.phase), 32'd0);
        check("t4_frame_count", 32'(bus.frame_count), 32'd2);
        // enable dropped mid-WAIT, cleared ignored while waiting.
        bus.enable = 1'b1;
        step();
        bus.cleared = 1'b1;
        step();
        bus.cleared = 1'b0;
        check("t4_cleared_ignored", 32'(bus.phase), 32'd1);
        bus.enable = 1'b0;
        step();
        check("t4_wait_abort", 32'(bus.phase), 32'd0);

        // Reset in the middle of CLEAR.
        bus.enable = 1'b1;
        advance_to(P_CLEAR, 10);
        bus.clr_x = 10'd1; bus.clr_y = 9'd1;
        step();
        check("t5_pre_we", 32'(bus.fb_we), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_phase", 32'(bus.phase), 32'd0);
        check("t5_clear_req", 32'(bus.clear_req), 32'd0);
        check("t5_we", 32'(bus.fb_we), 32'd0);
        check("t5_frame_count", 32'(bus.frame_count), 32'd0);

`ifdef FRAME_SEQ_TIMEOUT_EN
        // Watchdog forces DRAW after CLEAR_TIMEOUT cycles without cleared.
        advance_to(P_CLEAR, 10);
        for (int i = 1; i < CLEAR_TIMEOUT; i++) begin
            step();
            check("t6_still_clear", 32'(bus.phase), 32'd2);
        end
        step();
        check("t6_forced_draw", 32'(bus.phase), 32'd3);
        check("t6_draw_start", 32'(bus.draw_start), 32'd1);
        check("t6_err", 32'(bus.timeout_err), 32'd1);
        bus.draw_done = 1'b1;
        step();
        bus.draw_done = 1'b0;
        advance_to(P_CLEAR, 10);
        bus.cleared = 1'b1;
        step();
        bus.cleared = 1'b0;
        check("t6_err_sticky", 32'(bus.timeout_err), 32'd1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 199) == 0);
            bus.enable     = ($urandom_range(0, 9) != 0);
            bus.clr_x      = 10'($urandom_range(0, 5));
            bus.clr_y      = 9'($urandom_range(0, 4));
            bus.cleared    = ($urandom_range(0, 5) == 0);
            bus.draw_x     = 10'($urandom_range(0, 6));
            bus.draw_y     = 9'($urandom_range(0, 4));
            bus.draw_color = 1'($urandom_range(0, 1));
            bus.draw_valid = ($urandom_range(0, 1) == 1);
            bus.draw_done  = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
